mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_arb2.sv | 19 +
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, requester IDs and small helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int N_REQ      = 2;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_VID = 1'b1
    } req_id_t;

    localparam logic [3:0] WAIT_MAX = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == WAIT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not served last.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last_vid,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[REQ_CPU] && (!req[REQ_VID] || last_vid)) begin
            gnt[REQ_CPU] = 1'b1;
        end else if (req[REQ_VID]) begin
            gnt[REQ_VID] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read single-port RAM between a CPU (read/write) and a display (read-only) port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_q,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    // Handshake: a requester holds req/addr/data until it sees gnt in the same cycle;
    // that cycle is the RAM access. valid pulses exactly one cycle later, with *_q
    // carrying the read word (writes pulse valid but leave *_q alone).
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  arb_gnt;
    logic [N_REQ-1:0]  gnt;
    logic [N_REQ-1:0]  valid_r;
    logic              last_vid;
    logic              cpu_rd_r;
    logic [DATA_W-1:0] cpu_q_r;
    logic [DATA_W-1:0] vid_q_r;
    logic [3:0]        cpu_wait;
    logic [3:0]        vid_wait;

    assign req = {vid_req, cpu_req};

    rr_arb2 u_arb (
        .req      (req),
        .last_vid (last_vid),
        .gnt      (arb_gnt)
    );

    // Reset masks everything combinationally so a grant or a pending valid in the reset cycle vanishes.
    assign gnt        = reset ? '0 : arb_gnt;
    assign cpu_gnt    = gnt[REQ_CPU];
    assign vid_gnt    = gnt[REQ_VID];
    assign ram_wEn    = cpu_gnt & cpu_wren;
    assign ram_addr   = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
    assign ram_dataIn = cpu_gnt ? cpu_data : '0;

    assign cpu_valid = valid_r[REQ_CPU] & ~reset;
    assign vid_valid = valid_r[REQ_VID] & ~reset;
    assign cpu_q     = reset ? '0 : ((cpu_valid && cpu_rd_r) ? ram_dataOut : cpu_q_r);
    assign vid_q     = reset ? '0 : (vid_valid ? ram_dataOut : vid_q_r);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_vid <= 1'b1;
            valid_r  <= '0;
            cpu_rd_r <= 1'b0;
            cpu_q_r  <= '0;
            vid_q_r  <= '0;
        end else begin
            if (|gnt) begin
                last_vid <= gnt[REQ_VID];
            end
            valid_r  <= gnt;
            cpu_rd_r <= cpu_gnt & ~cpu_wren;
            cpu_q_r  <= cpu_q;
            vid_q_r  <= vid_q;
        end
    end

    // Wait counters only exist to bound starvation; an idle requester is not waiting.
    always_ff @(posedge clock) begin
        if (reset || !cpu_req || cpu_gnt) begin
            cpu_wait <= 4'd0;
        end else begin
            cpu_wait <= sat_inc(cpu_wait);
        end
        if (reset || !vid_req || vid_gnt) begin
            vid_wait <= 4'd0;
        end else begin
            vid_wait <= sat_inc(vid_wait);
        end
        if (!reset) begin
            assert (cpu_wait <= 4'd1 && vid_wait <= 4'd1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random contending traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wren, cpu_gnt, cpu_valid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data, cpu_q;
    logic          vid_req, vid_gnt, vid_valid;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_q;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_wren    (cpu_wren),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_gnt     (cpu_gnt),
        .cpu_valid   (cpu_valid),
        .cpu_q       (cpu_q),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_gnt     (vid_gnt),
        .vid_valid   (vid_valid),
        .vid_q       (vid_q),
        .ram_wEn     (ram_wEn),
        .ram_addr    (ram_addr),
        .ram_dataIn  (ram_dataIn),
        .ram_dataOut (ram_dataOut)
    );

    // Environment RAM: single port, registered read, with a backdoor preload port.
    logic [DW-1:0] ram [0:4095] = '{default: '0};
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            ram_writes = 0;

    always @(posedge clock) begin
        if (ram_wEn) begin
            ram[ram_addr] <= ram_dataIn;
            ram_writes    <= ram_writes + 1;
        end else if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end
        ram_dataOut <= ram[ram_addr];
    end

    // Reference model: memory contents, who was served last, and outstanding completions.
    logic [DW-1:0] shadow [0:4095] = '{default: '0};
    logic [DW-1:0] cpu_exp_q [$];
    logic [DW-1:0] vid_exp_q [$];
    logic [DW-1:0] cpu_q_m, vid_q_m;
    bit            last_vid_m, pend_c, pend_c_rd, pend_v;
    bit            g_c, g_v;
    int            exp_writes;
    int            n_checks, n_bad;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit c_req, input bit c_wr, input logic [AW-1:0] c_addr,
                        input logic [DW-1:0] c_data, input bit v_req, input logic [AW-1:0] v_addr);
        bit ec, ev;
        @(negedge clock);
        pre_en   = 1'b0;
        reset    = rst;
        cpu_req  = c_req;
        cpu_wren = c_wr;
        cpu_addr = c_addr;
        cpu_data = c_data;
        vid_req  = v_req;
        vid_addr = v_addr;
        #1;
        ec = !rst && c_req && (!v_req || last_vid_m);
        ev = !rst && v_req && !ec;
        if (rst) begin
            cpu_exp_q.delete();
            vid_exp_q.delete();
            cpu_q_m = '0;
            vid_q_m = '0;
        end else begin
            if (pend_c && pend_c_rd) cpu_q_m = cpu_exp_q.pop_front();
            if (pend_v) vid_q_m = vid_exp_q.pop_front();
        end
        check_eq("cpu_valid", 32'(cpu_valid), 32'(!rst && pend_c));
        check_eq("vid_valid", 32'(vid_valid), 32'(!rst && pend_v));
        check_eq("cpu_q", cpu_q, cpu_q_m);
        check_eq("vid_q", vid_q, vid_q_m);
        check_eq("cpu_gnt", 32'(cpu_gnt), 32'(ec));
        check_eq("vid_gnt", 32'(vid_gnt), 32'(ev));
        check_eq("gnt_excl", 32'(cpu_gnt & vid_gnt), 32'(0));
        check_eq("ram_wEn", 32'(ram_wEn), 32'(ec && c_wr));
        check_eq("ram_addr", 32'(ram_addr), ec ? 32'(c_addr) : (ev ? 32'(v_addr) : 32'(0)));
        check_eq("ram_dataIn", ram_dataIn, ec ? c_data : '0);
        pend_c    = ec;
        pend_c_rd = ec && !c_wr;
        pend_v    = ev;
        if (ec && !c_wr) cpu_exp_q.push_back(shadow[c_addr]);
        if (ev) vid_exp_q.push_back(shadow[v_addr]);
        if (ec && c_wr) begin
            shadow[c_addr] = c_data;
            exp_writes++;
        end
        if (rst) last_vid_m = 1'b1;
        else if (ec || ev) last_vid_m = ev;
        g_c = ec;
        g_v = ev;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [3:0]    seq;
        bit            act_c, act_v, wr;
        logic [AW-1:0] ac, av;
        logic [DW-1:0] dc;
        int            wc, wv, max_wc, max_wv;

        reset = 1'b1; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_data = '0;
        vid_req = 1'b0; vid_addr = '0;
        n_checks = 0; n_bad = 0; exp_writes = 0;
        last_vid_m = 1'b1; pend_c = 0; pend_c_rd = 0; pend_v = 0;
        cpu_q_m = '0; vid_q_m = '0;

        do_reset();
        do_reset();

        // CPU write then read-back of the same word
        step(1'b0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, '0);
        idle();
        step(1'b0, 1'b1, 1'b0, 12'h010, '0, 1'b0, '0);
        idle();
        check_eq("readback_0x010", cpu_q, 32'hDEADBEEF);

        // Contention straight after reset alternates, CPU first
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 12'h010, '0, 1'b1, 12'h011);
            seq[i] = cpu_gnt;
        end
        check_eq("rr_seq", 32'(seq), 32'(4'b0101));
        idle();

        // Display-only read of a preloaded word
        pre_addr = 12'h020; pre_data = 32'h7; pre_en = 1'b1;
        shadow[12'h020] = 32'h7;
        idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h020);
        idle();
        check_eq("vid_q_0x020", vid_q, 32'h7);
        check_eq("cpu_q_kept", cpu_q, 32'hDEADBEEF);

        // Reset right after a CPU write grant drops its completion
        step(1'b0, 1'b1, 1'b1, 12'h030, 32'h12345678, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 12'h030, '0, 1'b1, 12'h040);
        step(1'b0, 1'b1, 1'b0, 12'h030, '0, 1'b1, 12'h040);
        check_eq("post_reset_cpu_first", 32'(cpu_gnt), 32'(1));
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h040);
        check_eq("write_survives_reset", cpu_q, 32'h12345678);
        idle();

        // Random contending traffic
        act_c = 0; act_v = 0; wr = 0; ac = '0; av = '0; dc = '0;
        wc = 0; wv = 0; max_wc = 0; max_wv = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!act_c && $urandom_range(0, 3) != 0) begin
                act_c = 1'b1;
                wr    = 1'($urandom_range(0, 1));
                ac    = AW'($urandom_range(0, 15));
                dc    = $urandom;
            end
            if (!act_v && $urandom_range(0, 3) != 0) begin
                act_v = 1'b1;
                av    = AW'($urandom_range(0, 15));
            end
            step(1'b0, act_c, wr, ac, dc, act_v, av);
            wc = (act_c && !cpu_gnt) ? wc + 1 : 0;
            wv = (act_v && !vid_gnt) ? wv + 1 : 0;
            if (wc > max_wc) max_wc = wc;
            if (wv > max_wv) max_wv = wv;
            if (g_c) act_c = 1'b0;
            if (g_v) act_v = 1'b0;
        end
        idle();
        idle();
        check_eq("cpu_max_wait_gt1", 32'(max_wc > 1), 32'(0));
        check_eq("vid_max_wait_gt1", 32'(max_wv > 1), 32'(0));
        check_eq("ram_write_count", 32'(ram_writes), 32'(exp_writes));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
